// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional misaligned-redirect trap is enabled with IFU_MISALIGN_TRAP_EN.
package ifu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/ifu_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; used for the in-flight
// PC queue and for the fetch buffer. Head data is combinational (show-ahead).
module ifu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns PCF, issues in-order imem requests, buffers {pc, instr}
// for decode and discards stale responses after a redirect. Macro: IFU_MISALIGN_TRAP_EN.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = 64'h0000_0000_0000_0000,
    parameter int              MAX_OUTSTANDING = 2,
    parameter int              FB_DEPTH        = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pcplus4,
    output logic            if_fault,
    output ifu_state_e      dbg_state
);

    localparam int OS_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int FB_W = $clog2(FB_DEPTH) + 1;
    localparam int CW   = OS_W + FB_W;

    // Handshake rule on every channel: a transfer happens on a rising edge where
    // valid and ready are both high; a valid source holds its payload until then.
    // The response channel has no ready and is always accepted.

    ifu_state_e      r_state;
    ifu_state_e      w_state_nxt;
    logic [OS_W-1:0] r_drop_cnt;
    logic [OS_W-1:0] w_drop_nxt;
    logic [XLEN-1:0] r_pcf;

    logic            w_req_hs;
    logic            w_dec_hs;
    logic            w_fb_push;
    logic            w_fb_pop;
    logic [OS_W-1:0] w_outstanding;
    logic [OS_W-1:0] w_outstanding_new;
    logic [FB_W-1:0] w_fb_count;
    logic            w_if_empty;
    logic            w_if_full;
    logic            w_fb_empty;
    logic            w_fb_full;
    logic [XLEN-1:0] w_inflight_pc;
    logic [XLEN-1:0] w_redirect_tgt;
    logic            w_slot_ok;
    logic            w_credit_ok;
    logic            w_drain_ok;
    logic            w_fault_active;
    logic            w_req_block;
    logic [XLEN-1:0] w_fault_pc;
    fetch_entry_t    w_fb_in;
    fetch_entry_t    w_fb_head;

    assign w_req_hs = imem_req_valid & imem_req_ready;
    assign w_dec_hs = if_valid & if_ready;

    ifu_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_inflight_q (
        .clk         (clk),
        .rst         (reset),
        .i_flush     (1'b0),
        .i_push      (w_req_hs),
        .i_push_data (r_pcf),
        .i_pop       (imem_resp_valid),
        .o_head      (w_inflight_pc),
        .o_count     (w_outstanding),
        .o_empty     (w_if_empty),
        .o_full      (w_if_full)
    );

    // A response in the redirect cycle is stale and must not land in the buffer.
    assign w_fb_push      = imem_resp_valid & (r_drop_cnt == '0) & ~redirect_valid;
    assign w_fb_pop       = w_dec_hs & ~w_fault_active;
    assign w_fb_in.pc     = w_inflight_pc;
    assign w_fb_in.instr  = imem_resp_data;

    ifu_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FB_DEPTH)
    ) u_fetch_buf (
        .clk         (clk),
        .rst         (reset),
        .i_flush     (redirect_valid),
        .i_push      (w_fb_push),
        .i_push_data (w_fb_in),
        .i_pop       (w_fb_pop),
        .o_head      (w_fb_head),
        .o_count     (w_fb_count),
        .o_empty     (w_fb_empty),
        .o_full      (w_fb_full)
    );

`ifdef IFU_MISALIGN_TRAP_EN
    logic            r_fault;
    logic            r_req_block;
    logic [XLEN-1:0] r_fault_pc;
    logic            w_misalign;

    assign w_misalign     = (redirect_pc[1:0] != 2'b00);
    assign w_redirect_tgt = redirect_pc;

    // The trap entry stands in for an instruction; fetch stays parked until re-steered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault     <= 1'b0;
            r_req_block <= 1'b0;
            r_fault_pc  <= '0;
        end else if (redirect_valid) begin
            r_fault     <= w_misalign;
            r_req_block <= w_misalign;
            r_fault_pc  <= redirect_pc;
        end else if (r_fault && if_ready) begin
            r_fault     <= 1'b0;
        end
    end

    assign w_fault_active = r_fault;
    assign w_req_block    = r_req_block;
    assign w_fault_pc     = r_fault_pc;
`else
    assign w_redirect_tgt = redirect_pc & ~64'd3;
    assign w_fault_active = 1'b0;
    assign w_req_block    = 1'b0;
    assign w_fault_pc     = '0;
`endif

    assign w_outstanding_new = w_outstanding - r_drop_cnt;
    assign w_slot_ok   = (w_outstanding < OS_W'(MAX_OUTSTANDING));
    // Each request reserves a buffer slot, so responses can never overflow it.
    assign w_credit_ok = (CW'(w_outstanding) + CW'(w_fb_count)) <
                         (CW'(FB_DEPTH) + CW'(w_dec_hs));

    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (redirect_valid) begin
            w_drop_nxt = w_outstanding + OS_W'(w_req_hs) - OS_W'(imem_resp_valid);
        end else if (imem_resp_valid && (r_drop_cnt != '0)) begin
            w_drop_nxt = r_drop_cnt - OS_W'(1);
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_drop_cnt <= w_drop_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = (w_drop_nxt != '0) ? DRAIN : FETCH;
        end else if ((r_state == DRAIN) && (w_drop_nxt == '0)) begin
            w_state_nxt = FETCH;
        end
    end

    // FSM: outputs
    always_comb begin
        w_drain_ok = 1'b1;
        if (r_state == DRAIN) begin
            w_drain_ok = (CW'(r_drop_cnt) + CW'(w_outstanding_new)) < CW'(MAX_OUTSTANDING);
        end
        imem_req_valid = ~reset & ~w_req_block & w_slot_ok & w_credit_ok & w_drain_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcf <= RESET_PC;
        end else if (redirect_valid) begin
            r_pcf <= w_redirect_tgt;
        end else if (w_req_hs) begin
            r_pcf <= pc_inc(r_pcf);
        end
    end

    assign imem_req_addr = r_pcf;
    assign if_valid      = ~w_fb_empty | w_fault_active;
    assign if_instr      = w_fault_active ? NOP_INSTR : w_fb_head.instr;
    assign if_pc         = w_fault_active ? w_fault_pc : w_fb_head.pc;
    assign if_pcplus4    = pc_inc(if_pc);
    assign if_fault      = w_fault_active;
    assign dbg_state     = r_state;

    a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (w_outstanding != '0));
    a_inflight_room: assert property (@(posedge clk) disable iff (reset)
        w_req_hs |-> (!w_if_full || imem_resp_valid));
    a_inflight_nonempty: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> !w_if_empty);
    a_fetch_buf_room: assert property (@(posedge clk) disable iff (reset)
        w_fb_push |-> (!w_fb_full || w_fb_pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a 1-cycle in-order memory with a hold
// switch, plus a second instance started at the top of the address space.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [63:0] if_pcplus4;
  logic        if_fault;
  ifu_state_e  dbg_state;

  logic        wr_req_valid;
  logic [63:0] wr_req_addr;
  logic        wr_resp_valid;
  logic [31:0] wr_resp_data;
  logic        wr_if_valid;
  logic [31:0] wr_if_instr;
  logic [63:0] wr_if_pc;
  logic [63:0] wr_if_pcplus4;
  logic        wr_if_fault;
  ifu_state_e  wr_state;

  logic        mem_hold = 1'b0;
  logic [63:0] pend_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  // ---------------- DUTs ----------------
  instr_fetch_unit #(.RESET_PC(64'h1000), .MAX_OUTSTANDING(2), .FB_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_pcplus4(if_pcplus4), .if_fault(if_fault), .dbg_state(dbg_state)
  );

  instr_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .MAX_OUTSTANDING(2), .FB_DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(wr_req_valid), .imem_req_ready(1'b1), .imem_req_addr(wr_req_addr),
    .imem_resp_valid(wr_resp_valid), .imem_resp_data(wr_resp_data),
    .redirect_valid(1'b0), .redirect_pc(64'h0),
    .if_valid(wr_if_valid), .if_ready(1'b1), .if_instr(wr_if_instr), .if_pc(wr_if_pc),
    .if_pcplus4(wr_if_pcplus4), .if_fault(wr_if_fault), .dbg_state(wr_state)
  );

  // Main memory: accepted addresses queue up; one answered per cycle unless held.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) pend_q.push_back(imem_req_addr);
      if (!mem_hold && pend_q.size() > 0) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= instr_of(pend_q.pop_front());
      end else begin
        imem_resp_valid <= 1'b0;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_resp_valid <= 1'b0;
      wr_resp_data  <= 32'h0;
    end else begin
      wr_resp_valid <= wr_req_valid;
      wr_resp_data  <= instr_of(wr_req_addr);
    end
  end

  // ---------------- driver tasks ----------------
  task step();
    @(posedge clk);
    #2;
  endtask

  task do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    imem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task test_reset();
    reset = 1'b1;
    mem_hold = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid: got %b exp 0", imem_req_valid); end
    n_checks++;
    if (if_valid !== 1'b0) begin n_errors++; $display("FAIL reset_if_valid: got %b exp 0", if_valid); end
    n_checks++;
    if (if_fault !== 1'b0) begin n_errors++; $display("FAIL reset_if_fault: got %b exp 0", if_fault); end
    n_checks++;
    if (imem_req_addr !== 64'h1000) begin n_errors++; $display("FAIL reset_pcf: got %h exp 1000", imem_req_addr); end
    n_checks++;
    if (dbg_state !== FETCH) begin n_errors++; $display("FAIL reset_state: got %0d exp FETCH", dbg_state); end
    n_checks++;
    if (wr_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_errors++; $display("FAIL reset_wrap_pcf: got %h", wr_req_addr); end
  endtask

  task test_seq_stream();
    logic [63:0] exp_pc;
    mem_hold = 1'b0;
    do_reset();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000) begin
      n_errors++; $display("FAIL stream_req0: valid %b addr %h exp 1 1000", imem_req_valid, imem_req_addr);
    end
    step();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1004 || if_valid !== 1'b0) begin
      n_errors++; $display("FAIL stream_req1: valid %b addr %h if_valid %b exp 1 1004 0", imem_req_valid, imem_req_addr, if_valid);
    end
    step();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 64'h1000 || if_instr !== instr_of(64'h1000)) begin
      n_errors++; $display("FAIL stream_first: valid %b pc %h instr %h exp 1 1000 %h", if_valid, if_pc, if_instr, instr_of(64'h1000));
    end
    n_checks++;
    if (if_pcplus4 !== 64'h1004) begin n_errors++; $display("FAIL stream_pcplus4: got %h exp 1004", if_pcplus4); end
    for (int k = 3; k < 8; k++) begin
      step();
      exp_pc = 64'h1000 + 64'(4 * (k - 2));
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== instr_of(exp_pc)) begin
        n_errors++; $display("FAIL stream_sustain: valid %b pc %h exp pc %h", if_valid, if_pc, exp_pc);
      end
    end
  endtask

  task test_decode_stall();
    logic [63:0] exp_pc;
    int got;
    step();
    if_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== 64'h1018) begin
        n_errors++; $display("FAIL stall_hold: valid %b pc %h exp 1 1018", if_valid, if_pc);
      end
      if (i < 4) step();
    end
    n_checks++;
    if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL stall_req_drop: got %b exp 0", imem_req_valid); end
    if_ready = 1'b1;
    #1;
    exp_pc = 64'h1018;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      if (if_valid === 1'b1) begin
        n_checks++;
        if (if_pc !== exp_pc) begin n_errors++; $display("FAIL stall_release_pc: got %h exp %h", if_pc, exp_pc); end
        exp_pc = exp_pc + 64'd4;
        got++;
      end
      step();
    end
    n_checks++;
    if (got != 12) begin n_errors++; $display("FAIL stall_release_rate: got %0d exp 12", got); end
  endtask

  task test_req_backpressure();
    mem_hold = 1'b0;
    do_reset();
    imem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000) begin
        n_errors++; $display("FAIL req_hold: valid %b addr %h exp 1 1000", imem_req_valid, imem_req_addr);
      end
      step();
    end
    imem_req_ready = 1'b1;
    #1;
    step();
    n_checks++;
    if (imem_req_addr !== 64'h1004) begin n_errors++; $display("FAIL req_advance: got %h exp 1004", imem_req_addr); end
  endtask

  task test_redirect_drain();
    logic found;
    mem_hold = 1'b1;
    do_reset();
    step();
    step();
    n_checks++;
    if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL drain_max_outstanding: got %b exp 0", imem_req_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    #1;
    step();
    redirect_valid = 1'b0;
    mem_hold = 1'b0;
    #1;
    n_checks++;
    if (dbg_state !== DRAIN || if_valid !== 1'b0) begin
      n_errors++; $display("FAIL drain_enter: state %0d if_valid %b exp DRAIN 0", dbg_state, if_valid);
    end
    n_checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h2000) begin
      n_errors++; $display("FAIL drain_pcf: valid %b addr %h exp 0 2000", imem_req_valid, imem_req_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (if_valid === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || if_pc !== 64'h2000) begin
      n_errors++; $display("FAIL drain_first_pc: found %b pc %h exp 1 2000", found, if_pc);
    end
    n_checks++;
    if (dbg_state !== FETCH) begin n_errors++; $display("FAIL drain_exit: state %0d exp FETCH", dbg_state); end
  endtask

  task test_redirect_collision();
    logic found;
    mem_hold = 1'b0;
    do_reset();
    step();
    step();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 64'h1000 || imem_req_valid !== 1'b1) begin
      n_errors++; $display("FAIL collide_setup: if_valid %b pc %h req %b exp 1 1000 1", if_valid, if_pc, imem_req_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (if_valid !== 1'b0 || dbg_state !== DRAIN) begin
      n_errors++; $display("FAIL collide_flush: if_valid %b state %0d exp 0 DRAIN", if_valid, dbg_state);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (if_valid === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || if_pc !== 64'h3000) begin
      n_errors++; $display("FAIL collide_first_pc: found %b pc %h exp 1 3000", found, if_pc);
    end
    step();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 64'h3004) begin
      n_errors++; $display("FAIL collide_second_pc: valid %b pc %h exp 1 3004", if_valid, if_pc);
    end
  endtask

  task test_misalign();
    logic found;
    mem_hold = 1'b0;
    do_reset();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h3002;
    #1;
    step();
    redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
    if_ready = 1'b0;
    #1;
    n_checks++;
    if (if_fault !== 1'b1 || if_valid !== 1'b1 || if_pc !== 64'h3002) begin
      n_errors++; $display("FAIL trap_entry: fault %b valid %b pc %h exp 1 1 3002", if_fault, if_valid, if_pc);
    end
    n_checks++;
    if (if_instr !== 32'h0000_0013 || if_pcplus4 !== 64'h3006) begin
      n_errors++; $display("FAIL trap_payload: instr %h pcplus4 %h exp 00000013 3006", if_instr, if_pcplus4);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (imem_req_valid !== 1'b0 || if_fault !== 1'b1) begin
        n_errors++; $display("FAIL trap_hold: req %b fault %b exp 0 1", imem_req_valid, if_fault);
      end
      step();
    end
    if_ready = 1'b1;
    #1;
    step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (if_fault !== 1'b0 || if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        n_errors++; $display("FAIL trap_cleared: fault %b valid %b req %b exp 0 0 0", if_fault, if_valid, imem_req_valid);
      end
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h4000;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (if_valid === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || if_pc !== 64'h4000 || if_fault !== 1'b0) begin
      n_errors++; $display("FAIL trap_resume: found %b pc %h fault %b exp 1 4000 0", found, if_pc, if_fault);
    end
`else
    #1;
    n_checks++;
    if (if_fault !== 1'b0) begin n_errors++; $display("FAIL misalign_no_fault: got %b exp 0", if_fault); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (if_valid === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || if_pc !== 64'h3000 || if_fault !== 1'b0) begin
      n_errors++; $display("FAIL misalign_masked: found %b pc %h fault %b exp 1 3000 0", found, if_pc, if_fault);
    end
`endif
  endtask

  task test_pc_wrap();
    mem_hold = 1'b0;
    do_reset();
    n_checks++;
    if (wr_req_valid !== 1'b1 || wr_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_errors++; $display("FAIL wrap_req0: valid %b addr %h", wr_req_valid, wr_req_addr);
    end
    step();
    n_checks++;
    if (wr_req_addr !== 64'h0) begin n_errors++; $display("FAIL wrap_req1: got %h exp 0", wr_req_addr); end
    step();
    n_checks++;
    if (wr_if_valid !== 1'b1 || wr_if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || wr_if_pcplus4 !== 64'h0 ||
        wr_if_instr !== instr_of(64'hFFFF_FFFF_FFFF_FFFC)) begin
      n_errors++; $display("FAIL wrap_head: valid %b pc %h pcplus4 %h instr %h", wr_if_valid, wr_if_pc, wr_if_pcplus4, wr_if_instr);
    end
    step();
    n_checks++;
    if (wr_if_pc !== 64'h0 || wr_if_pcplus4 !== 64'h4 || wr_if_fault !== 1'b0 || wr_state !== FETCH) begin
      n_errors++; $display("FAIL wrap_next: pc %h pcplus4 %h fault %b state %0d exp 0 4 0 FETCH", wr_if_pc, wr_if_pcplus4, wr_if_fault, wr_state);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_seq_stream();
    test_decode_stall();
    test_req_backpressure();
    test_redirect_drain();
    test_redirect_collision();
    test_misalign();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front end of the fetch stage. Owns the architectural fetch PC and issues sequential requests to instruction memory over a valid/ready request channel. It collects in-order instruction responses and hands {pc, instr, pc+4} pairs to decode through a small fetch buffer. Execute redirects (taken branch or jump) re-steer the PC and discard stale in-flight responses.

Parameters:
RESET_PC, 64'h0000_0000_0000_0000, fetch PC loaded on reset.
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests (power of 2, ≥1).
FB_DEPTH, 2, fetch buffer entries (power of 2, ≥1).

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high.
imem_req_valid  out  1  request address valid.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  64  fetch address (current PCF).
imem_resp_valid  in  1  in-order response; always accepted, no backpressure.
imem_resp_data  in  32  instruction word.
redirect_valid  in  1  execute redirect.
redirect_pc  in  64  redirect target.
if_valid  out  1  fetch buffer head valid.
if_ready  in  1  decode accepts head.
if_instr  out  32  head instruction.
if_pc  out  64  head PC.
if_pcplus4  out  64  head PC + 4, modulo 2^64.
if_fault  out  1  misaligned-target fault (IFU_MISALIGN_TRAP_EN only; tied 0 otherwise).

Behaviour:
- Reset (async, active-high). State = FETCH. PCF = RESET_PC. imem_req_valid = 0. if_valid = 0. if_fault = 0. All counts and queues cleared.
- States:
  - FETCH: normal fetching.
  - DRAIN: redirect occurred while stale requests were outstanding. New requests to the new PC are issued in DRAIN only while drop_cnt + outstanding_new < MAX_OUTSTANDING. DRAIN → FETCH when drop_cnt reaches 0.
- Request issue: imem_req_valid = 1 iff (outstanding < MAX_OUTSTANDING) and (outstanding + fb_count < FB_DEPTH + (if_valid & if_ready)). This credit scheme guarantees responses never overflow the buffer.
- imem_req_addr = PCF, held stable while valid & !ready.
- On request handshake, PCF ← PCF + 4 (wraps at 2^64) and PCF is pushed into the in-flight PC queue (depth MAX_OUTSTANDING).
- Response with drop_cnt = 0: pop the in-flight PC queue and push {pc, imem_resp_data} into the fetch buffer.
- Response with drop_cnt > 0: decrement drop_cnt, pop the in-flight queue, do not write the buffer.
- Minimum latency: request handshake in cycle t, response in t+1, if_valid in t+2. There is no bypass.
- Decode handshake (if_valid & if_ready) pops the head. A simultaneous push and pop keeps fb_count unchanged.
- Redirect in cycle t:
  - Next edge: PCF ← redirect_pc, fetch buffer flushed (if_valid = 0 at t+1), drop_cnt ← all in-flight requests, including one handshaking in cycle t and excluding a response arriving in t (that response is itself dropped).
  - If the resulting drop_cnt > 0, go to DRAIN; otherwise stay in FETCH.
  - A decode handshake in cycle t completes normally.
  - A redirect while in DRAIN reloads PCF and adds new-PC requests to drop_cnt.
  - redirect_valid has priority over the sequential PC increment.
- if_valid, if_instr and if_pc hold stable while if_ready = 0.
- imem_resp_valid with no outstanding request is a protocol violation; it is covered by an assertion, not by handling logic.

Optional Feature:
IFU_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0] ≠ 0 sets if_fault = 1 and if_pc = redirect_pc, with if_valid = 1 and if_instr = 32'h0000_0013 (NOP). Requests are suppressed until the next redirect or reset. if_fault clears on the decode handshake.
- Undefined: redirect_pc[1:0] is forced to 0 and if_fault is tied 0.

Decomposition:
- Package ifu_pkg holds:
  - XLEN = 64, ILEN = 32;
  - NOP_INSTR = 32'h0000_0013;
  - typedef enum {FETCH, DRAIN} ifu_state_e;
  - typedef struct packed {logic [63:0] pc; logic [31:0] instr;} fetch_entry_t.
- One sub-module, ifu_sync_fifo (parameterised width/depth, flush input, count output). It is instantiated twice: as the in-flight PC queue and as the fetch buffer.

Test Plan:
- Sequential stream: reset with RESET_PC = 0x1000, memory ready always, 1-cycle response → addresses 0x1000, 0x1004, 0x1008…; if_pc 0x1000 appears at cycle 2 with if_pcplus4 = 0x1004; one instruction per cycle sustained.
- Decode stall: hold if_ready = 0 for 5 cycles → at most FB_DEPTH buffered, imem_req_valid drops, no lost or duplicated PCs on release.
- Redirect with 2 outstanding: redirect_pc = 0x2000 → both stale responses dropped, next if_pc = 0x2000, state passes through DRAIN.
- Simultaneous redirect and response, plus a request handshake in the same cycle → neither the stale response nor the stale request's data reaches decode.
- PC wrap: RESET_PC = 0xFFFF_FFFF_FFFF_FFFC → second request address 0x0, if_pcplus4 = 0x0.
- With IFU_MISALIGN_TRAP_EN: redirect_pc = 0x3002 → if_fault = 1, if_pc = 0x3002, no imem requests until the next redirect.
